rename_table_gen: RTL and testbench

RENAME_TABLE_GEN -- requirements
Module: rename_table_gen

---
 rtl/rename_table_gen.sv | 146 ++++++++++++++
 tb/tb_rename_table_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_table_gen.sv
// Checkpointed register rename table: arch->phys mapping with ready bits per version,
// a commit table for full-flush recovery, and registered source/old-dest lookups.
module rename_table_gen #(
  parameter int NUM_ARCH_REGS   = 32,
  parameter int PHYS_W          = 6,
  parameter int NUM_CHECKPOINTS = 4,
  parameter int NUM_SRC         = 3,
  parameter int NUM_WB          = 2,
  parameter int ZERO_REG        = 0,
  localparam int ARCH_W = $clog2(NUM_ARCH_REGS),
  localparam int CP_W   = $clog2(NUM_CHECKPOINTS)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_SRC-1:0][ARCH_W-1:0]   read_src_i,
  input  logic [ARCH_W-1:0]                old_dst_i,
  input  logic                             write_dst_i,
  input  logic [PHYS_W-1:0]                new_dst_i,
  input  logic [NUM_WB-1:0]                ready_i,
  input  logic [NUM_WB-1:0][ARCH_W-1:0]    vaddr_i,
  input  logic [NUM_WB-1:0][PHYS_W-1:0]    paddr_i,
  input  logic                             recover_commit_i,
  input  logic [ARCH_W-1:0]                commit_old_dst_i,
  input  logic                             commit_write_dst_i,
  input  logic [PHYS_W-1:0]                commit_new_dst_i,
  input  logic                             do_checkpoint_i,
  input  logic                             do_recover_i,
  input  logic                             delete_checkpoint_i,
  input  logic [CP_W-1:0]                  recover_checkpoint_i,
  output logic [NUM_SRC-1:0][PHYS_W-1:0]   src_o,
  output logic [NUM_SRC-1:0]               rdy_o,
  output logic [PHYS_W-1:0]                old_dst_o,
  output logic [CP_W-1:0]                  checkpoint_o,
  output logic                             checkpoint_taken_o,
  output logic                             out_of_checkpoints_o
);

  localparam logic [CP_W-1:0] CP_LAST = CP_W'(NUM_CHECKPOINTS - 1);

  logic [PHYS_W-1:0]        r_map    [NUM_CHECKPOINTS][NUM_ARCH_REGS];
  logic [NUM_ARCH_REGS-1:0] r_rdy    [NUM_CHECKPOINTS];
  logic [PHYS_W-1:0]        r_commit [NUM_ARCH_REGS];
  logic [CP_W-1:0]          r_head, r_tail, r_count;

  logic                     w_ren, w_cp_en, w_cwr;
  logic [CP_W-1:0]          w_head_nxt;
  logic [NUM_ARCH_REGS-1:0] w_wb_hit [NUM_CHECKPOINTS];
  logic [PHYS_W-1:0]        w_hmap   [NUM_ARCH_REGS];
  logic [NUM_ARCH_REGS-1:0] w_hrdy;
  logic [NUM_SRC-1:0][PHYS_W-1:0] w_src;
  logic [NUM_SRC-1:0]             w_src_rdy;

  assign w_ren   = write_dst_i && !recover_commit_i && !do_recover_i &&
                   !(ZERO_REG != 0 && old_dst_i == '0);
  assign w_cp_en = do_checkpoint_i && (r_count < CP_LAST) && !do_recover_i && !recover_commit_i;
  assign w_cwr   = commit_write_dst_i && !recover_commit_i &&
                   !(ZERO_REG != 0 && commit_old_dst_i == '0);
  assign w_head_nxt = r_head + 1'b1;

  // Writeback wakeup: a version's entry goes ready when its current mapping matches the tag.
  always_comb begin
    for (int v = 0; v < NUM_CHECKPOINTS; v++) begin
      w_wb_hit[v] = '0;
      for (int r = 0; r < NUM_ARCH_REGS; r++)
        for (int w = 0; w < NUM_WB; w++)
          if (ready_i[w] && vaddr_i[w] == ARCH_W'(r) && paddr_i[w] == r_map[v][r])
            w_wb_hit[v][r] = 1'b1;
    end
  end

  // Next head contents; clearing the renamed bit after the OR also masks a same-cycle wakeup.
  always_comb begin
    for (int r = 0; r < NUM_ARCH_REGS; r++) w_hmap[r] = r_map[r_head][r];
    w_hrdy = r_rdy[r_head] | w_wb_hit[r_head];
    if (w_ren) begin
      w_hmap[old_dst_i] = new_dst_i;
      w_hrdy[old_dst_i] = 1'b0;
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    always_comb begin
      w_src[s]     = r_map[r_head][read_src_i[s]];
      w_src_rdy[s] = r_rdy[r_head][read_src_i[s]];
      for (int w = 0; w < NUM_WB; w++)
        if (ready_i[w] && vaddr_i[w] == read_src_i[s] && paddr_i[w] == w_src[s])
          w_src_rdy[s] = 1'b1;
      if (ZERO_REG != 0 && read_src_i[s] == '0) begin
        w_src[s]     = '0;
        w_src_rdy[s] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int v = 0; v < NUM_CHECKPOINTS; v++) begin
        for (int r = 0; r < NUM_ARCH_REGS; r++) r_map[v][r] <= PHYS_W'(r);
        r_rdy[v] <= '1;
      end
      for (int r = 0; r < NUM_ARCH_REGS; r++) r_commit[r] <= PHYS_W'(r);
      r_head             <= '0;
      r_tail             <= '0;
      r_count            <= '0;
      src_o              <= '0;
      rdy_o              <= '0;
      old_dst_o          <= '0;
      checkpoint_taken_o <= 1'b0;
    end else if (recover_commit_i) begin
      for (int r = 0; r < NUM_ARCH_REGS; r++) r_map[0][r] <= r_commit[r];
      for (int v = 0; v < NUM_CHECKPOINTS; v++) r_rdy[v] <= '1;
      r_head             <= '0;
      r_tail             <= '0;
      r_count            <= '0;
      src_o              <= '0;
      rdy_o              <= '0;
      old_dst_o          <= '0;
      checkpoint_taken_o <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_CHECKPOINTS; v++) r_rdy[v] <= r_rdy[v] | w_wb_hit[v];
      if (!do_recover_i) begin
        for (int r = 0; r < NUM_ARCH_REGS; r++) r_map[r_head][r] <= w_hmap[r];
        r_rdy[r_head] <= w_hrdy;
        if (w_cp_en) begin
          for (int r = 0; r < NUM_ARCH_REGS; r++) r_map[w_head_nxt][r] <= w_hmap[r];
          r_rdy[w_head_nxt] <= w_hrdy;
          r_head            <= w_head_nxt;
        end
        r_count   <= r_count + CP_W'(w_cp_en) - CP_W'(delete_checkpoint_i);
        src_o     <= w_src;
        rdy_o     <= w_src_rdy;
        old_dst_o <= r_map[r_head][old_dst_i];
      end else begin
        r_head  <= recover_checkpoint_i;
        r_count <= recover_checkpoint_i - r_tail;
      end
      r_tail             <= r_tail + CP_W'(delete_checkpoint_i);
      checkpoint_taken_o <= w_cp_en;
      if (w_cwr) r_commit[commit_old_dst_i] <= commit_new_dst_i;
    end
  end

  assign checkpoint_o         = r_head;
  assign out_of_checkpoints_o = (r_count == CP_LAST);

endmodule

// File: tb/tb_rename_table_gen.sv
// Bench for rename_table_gen (integer mode): directed vector table, then random
// traffic checked against an array-based model of the rename versions.
module tb_rename_table_gen;
  localparam int NAR = 32, PW = 6, NC = 4, NS = 3, NW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NS-1:0][4:0] read_src;
  logic [4:0]         old_dst;
  logic               write_dst;
  logic [5:0]         new_dst;
  logic [NW-1:0]      ready;
  logic [NW-1:0][4:0] vaddr;
  logic [NW-1:0][5:0] paddr;
  logic               rcmt, cwr;
  logic [4:0]         cod;
  logic [5:0]         cnd;
  logic               do_cp, do_rec, del;
  logic [1:0]         rid;
  logic [NS-1:0][5:0] src_o;
  logic [NS-1:0]      rdy_o;
  logic [5:0]         old_o;
  logic [1:0]         cpo;
  logic               ct, ooc;

  rename_table_gen #(.NUM_ARCH_REGS(NAR), .PHYS_W(PW), .NUM_CHECKPOINTS(NC),
                     .NUM_SRC(NS), .NUM_WB(NW), .ZERO_REG(1)) dut (
    .clk_i(clk), .rst_i(rst), .read_src_i(read_src), .old_dst_i(old_dst),
    .write_dst_i(write_dst), .new_dst_i(new_dst), .ready_i(ready), .vaddr_i(vaddr),
    .paddr_i(paddr), .recover_commit_i(rcmt), .commit_old_dst_i(cod),
    .commit_write_dst_i(cwr), .commit_new_dst_i(cnd), .do_checkpoint_i(do_cp),
    .do_recover_i(do_rec), .delete_checkpoint_i(del), .recover_checkpoint_i(rid),
    .src_o(src_o), .rdy_o(rdy_o), .old_dst_o(old_o), .checkpoint_o(cpo),
    .checkpoint_taken_o(ct), .out_of_checkpoints_o(ooc));

  typedef struct packed {
    logic [2:0][4:0] src;
    logic            wr;
    logic [4:0]      od;
    logic [5:0]      nd;
    logic [1:0]      rd;
    logic [1:0][4:0] va;
    logic [1:0][5:0] pa;
    logic            rc, cw;
    logic [4:0]      cod;
    logic [5:0]      cnd;
    logic            cp, rec, del;
    logic [1:0]      rid;
  } in_t;

  typedef struct {
    in_t        i;
    logic [5:0] e_s0;
    logic       e_r0;
    logic [1:0] e_cpo;
    logic       e_ct;
    logic       e_oc;
  } vec_t;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t x);
    read_src = x.src; write_dst = x.wr; old_dst = x.od; new_dst = x.nd;
    ready = x.rd; vaddr = x.va; paddr = x.pa; rcmt = x.rc; cwr = x.cw;
    cod = x.cod; cnd = x.cnd; do_cp = x.cp; do_rec = x.rec; del = x.del; rid = x.rid;
  endtask

  // Reference model: each version is a plain array; applied in spec order per cycle.
  int m_map [NC][NAR];
  bit m_rdy [NC][NAR];
  int m_com [NAR];
  int m_head, m_tail, m_cnt;
  int e_src [NS];
  bit e_rdy [NS];
  int e_old, e_cpo;
  bit e_ct;

  task automatic m_reset();
    for (int v = 0; v < NC; v++)
      for (int r = 0; r < NAR; r++) begin m_map[v][r] = r; m_rdy[v][r] = 1'b1; end
    for (int r = 0; r < NAR; r++) m_com[r] = r;
    m_head = 0; m_tail = 0; m_cnt = 0;
    for (int s = 0; s < NS; s++) begin e_src[s] = 0; e_rdy[s] = 1'b0; end
    e_old = 0; e_cpo = 0; e_ct = 1'b0;
  endtask

  task automatic m_step(input in_t x);
    bit ren, cpen;
    int a, nh;
    if (x.rc) begin
      for (int r = 0; r < NAR; r++) m_map[0][r] = m_com[r];
      for (int v = 0; v < NC; v++)
        for (int r = 0; r < NAR; r++) m_rdy[v][r] = 1'b1;
      m_head = 0; m_tail = 0; m_cnt = 0;
      for (int s = 0; s < NS; s++) begin e_src[s] = 0; e_rdy[s] = 1'b0; end
      e_old = 0; e_ct = 1'b0;
    end else begin
      if (!x.rec) begin
        for (int s = 0; s < NS; s++) begin
          a = int'(x.src[s]);
          if (a == 0) begin e_src[s] = 0; e_rdy[s] = 1'b1; end
          else begin
            e_src[s] = m_map[m_head][a];
            e_rdy[s] = m_rdy[m_head][a];
            for (int w = 0; w < NW; w++)
              if (x.rd[w] && int'(x.va[w]) == a && int'(x.pa[w]) == e_src[s]) e_rdy[s] = 1'b1;
          end
        end
        e_old = m_map[m_head][x.od];
      end
      ren  = x.wr && x.od != 0 && !x.rec;
      cpen = x.cp && m_cnt < NC - 1 && !x.rec;
      for (int v = 0; v < NC; v++)
        for (int w = 0; w < NW; w++)
          if (x.rd[w] && m_map[v][x.va[w]] == int'(x.pa[w]) &&
              !(v == m_head && ren && x.va[w] == x.od))
            m_rdy[v][x.va[w]] = 1'b1;
      if (!x.rec) begin
        if (ren) begin m_map[m_head][x.od] = int'(x.nd); m_rdy[m_head][x.od] = 1'b0; end
        if (cpen) begin
          nh = (m_head + 1) % NC;
          for (int r = 0; r < NAR; r++) begin
            m_map[nh][r] = m_map[m_head][r]; m_rdy[nh][r] = m_rdy[m_head][r];
          end
          m_head = nh;
        end
        m_cnt = (m_cnt + int'(cpen) - int'(x.del) + NC) % NC;
      end else begin
        m_head = int'(x.rid);
        m_cnt  = (int'(x.rid) - m_tail + NC) % NC;
      end
      m_tail = (m_tail + int'(x.del)) % NC;
      e_ct = cpen;
      if (x.cw && x.cod != 0) m_com[x.cod] = int'(x.cnd);
    end
    e_cpo = m_head;
  endtask

  function automatic vec_t mk(input int s0, input int es0, input bit er0,
                              input int ecpo, input bit ect, input bit eoc);
    vec_t v;
    v.i = '0;
    v.i.src[0] = 5'(s0);
    v.e_s0 = 6'(es0); v.e_r0 = er0; v.e_cpo = 2'(ecpo); v.e_ct = ect; v.e_oc = eoc;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t v;
    in_t  x;
    int   k;

    // s0, exp src0, exp rdy0, exp checkpoint_o, exp taken, exp out_of_checkpoints
    tbl.push_back(mk(5, 5, 1, 0, 0, 0));
    v = mk(3, 3, 1, 0, 0, 0); v.i.wr = 1; v.i.od = 3; v.i.nd = 40; tbl.push_back(v);
    tbl.push_back(mk(3, 40, 0, 0, 0, 0));
    v = mk(3, 40, 1, 0, 0, 0); v.i.rd = 2'b01; v.i.va[0] = 3; v.i.pa[0] = 40; tbl.push_back(v);
    tbl.push_back(mk(3, 40, 1, 0, 0, 0));
    v = mk(7, 7, 1, 1, 1, 0); v.i.cp = 1; v.i.wr = 1; v.i.od = 7; v.i.nd = 50; tbl.push_back(v);
    v = mk(7, 50, 0, 2, 1, 0); v.i.cp = 1; tbl.push_back(v);
    v = mk(7, 50, 0, 3, 1, 1); v.i.cp = 1; tbl.push_back(v);
    v = mk(0, 0, 1, 3, 0, 1);  v.i.cp = 1; tbl.push_back(v);
    v = mk(7, 50, 0, 3, 0, 1); v.i.wr = 1; v.i.od = 7; v.i.nd = 60; tbl.push_back(v);
    tbl.push_back(mk(7, 60, 0, 3, 0, 1));
    v = mk(7, 60, 0, 3, 0, 0); v.i.del = 1; tbl.push_back(v);
    v = mk(7, 60, 0, 3, 0, 0); v.i.del = 1; tbl.push_back(v);
    v = mk(7, 60, 0, 3, 0, 0); v.i.del = 1; tbl.push_back(v);
    // tail=3 > recover id 1: count wraps to 2
    v = mk(7, 60, 0, 1, 0, 0); v.i.rec = 1; v.i.rid = 1; tbl.push_back(v);
    tbl.push_back(mk(7, 50, 0, 1, 0, 0));
    v = mk(2, 2, 1, 1, 0, 0); v.i.cw = 1; v.i.cod = 2; v.i.cnd = 33; tbl.push_back(v);
    v = mk(2, 0, 0, 0, 0, 0); v.i.rc = 1; tbl.push_back(v);
    tbl.push_back(mk(2, 33, 1, 0, 0, 0));
    tbl.push_back(mk(3, 3, 1, 0, 0, 0));
    v = mk(0, 0, 1, 0, 0, 0); v.i.wr = 1; v.i.od = 0; v.i.nd = 45; tbl.push_back(v);
    tbl.push_back(mk(0, 0, 1, 0, 0, 0));

    x = '0;
    drive(x);
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) begin
      chk($sformatf("reset_src%0d", s), 32'(src_o[s]), 0);
      chk($sformatf("reset_rdy%0d", s), 32'(rdy_o[s]), 0);
    end
    chk("reset_old", 32'(old_o), 0);
    chk("reset_cpo", 32'(cpo), 0);
    chk("reset_taken", 32'(ct), 0);
    chk("reset_ooc", 32'(ooc), 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].i);
      m_step(tbl[i].i);
      @(posedge clk);
      #1;
      chk($sformatf("dir%0d_src0", i), 32'(src_o[0]), 32'(tbl[i].e_s0));
      chk($sformatf("dir%0d_rdy0", i), 32'(rdy_o[0]), 32'(tbl[i].e_r0));
      chk($sformatf("dir%0d_cpo", i),  32'(cpo),       32'(tbl[i].e_cpo));
      chk($sformatf("dir%0d_taken", i), 32'(ct),       32'(tbl[i].e_ct));
      chk($sformatf("dir%0d_ooc", i),  32'(ooc),       32'(tbl[i].e_oc));
    end

    for (int n = 0; n < 600; n++) begin
      x = '0;
      for (int s = 0; s < NS; s++) x.src[s] = 5'($urandom_range(0, NAR - 1));
      x.wr = 1'($urandom_range(0, 1));
      x.od = 5'($urandom_range(0, NAR - 1));
      x.nd = 6'($urandom_range(0, 63));
      for (int w = 0; w < NW; w++) begin
        x.rd[w] = 1'($urandom_range(0, 1));
        x.va[w] = 5'($urandom_range(0, NAR - 1));
        k = $urandom_range(0, NC - 1);
        x.pa[w] = ($urandom_range(0, 3) != 0) ? 6'(m_map[k][x.va[w]]) : 6'($urandom_range(0, 63));
      end
      x.rc  = ($urandom_range(0, 59) == 0);
      x.cw  = ($urandom_range(0, 2) == 0);
      x.cod = 5'($urandom_range(0, NAR - 1));
      x.cnd = 6'($urandom_range(0, 63));
      x.cp  = ($urandom_range(0, 2) == 0);
      x.rec = ($urandom_range(0, 14) == 0);
      x.del = (m_cnt > 0) && ($urandom_range(0, 3) == 0);
      x.rid = 2'($urandom_range(0, NC - 1));
      drive(x);
      m_step(x);
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) begin
        chk($sformatf("rnd%0d_src%0d", n, s), 32'(src_o[s]), 32'(e_src[s]));
        chk($sformatf("rnd%0d_rdy%0d", n, s), 32'(rdy_o[s]), 32'(e_rdy[s]));
      end
      chk($sformatf("rnd%0d_old", n),   32'(old_o), 32'(e_old));
      chk($sformatf("rnd%0d_cpo", n),   32'(cpo),   32'(e_cpo));
      chk($sformatf("rnd%0d_taken", n), 32'(ct),    32'(e_ct));
      chk($sformatf("rnd%0d_ooc", n),   32'(ooc),   32'(m_cnt == NC - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
